cond_logic: RTL and testbench

Conditional-execution stage of the single-cycle processor, directly downstream of the ALU decoder. Holds the architectural NZCV flag register, evaluates the 4-bit instruction condition field against the stored flags, and gates the control unit's write enables (PC, register file, memory, flags). Consumes FlagW and NoWrite from the ALU decoder and ALUFlags from the ALU.

---
 rtl/cond_pkg.sv | 31 +++
 rtl/cond_check.sv | 42 ++++
 rtl/cond_logic.sv | 70 +++++++
 tb/tb_cond_logic.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared encodings for the conditional-execution stage: condition field values
// and bit positions within the NZCV flag vector and FlagW.
package cond_pkg;

   localparam int FLAG_N   = 3;
   localparam int FLAG_Z   = 2;
   localparam int FLAG_C   = 1;
   localparam int FLAG_V   = 0;
   localparam int FLAGW_NZ = 1;
   localparam int FLAGW_CV = 0;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of the instruction condition field against the
// stored NZCV flags.
module cond_check
   import cond_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n_s, z_s, c_s, v_s;

   assign n_s = Flags[FLAG_N];
   assign z_s = Flags[FLAG_Z];
   assign c_s = Flags[FLAG_C];
   assign v_s = Flags[FLAG_V];

   // Condition table; the reserved encoding never executes.
   always_comb begin
      CondEx = 1'b0;
      case (cond_e'(Cond))
         COND_EQ: CondEx = z_s;
         COND_NE: CondEx = ~z_s;
         COND_CS: CondEx = c_s;
         COND_CC: CondEx = ~c_s;
         COND_MI: CondEx = n_s;
         COND_PL: CondEx = ~n_s;
         COND_VS: CondEx = v_s;
         COND_VC: CondEx = ~v_s;
         COND_HI: CondEx = c_s & ~z_s;
         COND_LS: CondEx = ~c_s | z_s;
         COND_GE: CondEx = (n_s == v_s);
         COND_LT: CondEx = (n_s != v_s);
         COND_GT: CondEx = ~z_s & (n_s == v_s);
         COND_LE: CondEx = z_s | (n_s != v_s);
         COND_AL: CondEx = 1'b1;
         COND_NV: CondEx = 1'b0;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds the NZCV flag register and gates the
// control unit's write enables by the evaluated condition.
module cond_logic
   import cond_pkg::*;
#(
   parameter int NUM_FLAGS = 4
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [3:0]           Cond,
   input  logic [NUM_FLAGS-1:0] ALUFlags,
   input  logic [1:0]           FlagW,
   input  logic                 PCS,
   input  logic                 RegW,
   input  logic                 MemW,
   input  logic                 NoWrite,
   output logic                 PCSrc,
   output logic                 RegWrite,
   output logic                 MemWrite,
   output logic [NUM_FLAGS-1:0] Flags,
   output logic                 CondEx
);

   logic [NUM_FLAGS-1:0] flags_r;
   logic                 condex_s;
   logic                 gate_s;
   logic                 wr_nz_s;
   logic                 wr_cv_s;

   cond_check u_check (
      .Cond   (Cond),
      .Flags  (flags_r),
      .CondEx (condex_s)
   );

   // rst_n only gates the outputs; the flag register relies on its async clear.
   assign gate_s   = condex_s & en & rst_n;
   assign wr_nz_s  = FlagW[FLAGW_NZ] & condex_s & en;
   assign wr_cv_s  = FlagW[FLAGW_CV] & condex_s & en;

   assign PCSrc    = PCS & gate_s;
   assign MemWrite = MemW & gate_s;
   assign RegWrite = RegW & ~NoWrite & gate_s;
   assign CondEx   = condex_s & rst_n;
   assign Flags    = flags_r;

   // Flag register with independently enabled {N,Z} and {C,V} halves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_r <= {NUM_FLAGS{1'b0}};
      end else begin
         if (wr_nz_s) begin
            flags_r[FLAG_N] <= ALUFlags[FLAG_N];
            flags_r[FLAG_Z] <= ALUFlags[FLAG_Z];
         end else begin
            flags_r[FLAG_N] <= flags_r[FLAG_N];
            flags_r[FLAG_Z] <= flags_r[FLAG_Z];
         end
         if (wr_cv_s) begin
            flags_r[FLAG_C] <= ALUFlags[FLAG_C];
            flags_r[FLAG_V] <= ALUFlags[FLAG_V];
         end else begin
            flags_r[FLAG_C] <= flags_r[FLAG_C];
            flags_r[FLAG_V] <= flags_r[FLAG_V];
         end
      end
   end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed vector table, mid-cycle reset,
// full Cond x Flags sweep, and randomized cycles against a reference model.
module tb_cond_logic;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, RegW, MemW, NoWrite;
   logic       PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0] Flags;

   int total = 0;
   int bad   = 0;

   cond_logic dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .Cond     (Cond),
      .ALUFlags (ALUFlags),
      .FlagW    (FlagW),
      .PCS      (PCS),
      .RegW     (RegW),
      .MemW     (MemW),
      .NoWrite  (NoWrite),
      .PCSrc    (PCSrc),
      .RegWrite (RegWrite),
      .MemWrite (MemWrite),
      .Flags    (Flags),
      .CondEx   (CondEx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // field order: rst_n en cond alu fw pcs regw memw nowr exp_ctl exp_flags exp_next
   // exp_ctl = {PCSrc, RegWrite, MemWrite, CondEx}
   typedef struct {
      logic       rst_n;
      logic       en;
      logic [3:0] cond;
      logic [3:0] alu;
      logic [1:0] fw;
      logic       pcs;
      logic       regw;
      logic       memw;
      logic       nowr;
      logic [3:0] exp_ctl;
      logic [3:0] exp_flags;
      logic [3:0] exp_next;
   } vec_t;

   vec_t       vecs [14];
   logic [3:0] mflags;

   // Conditions come in complementary pairs: even code tests a predicate, odd
   // code its inverse; 1110 always runs, 1111 never does.
   function automatic bit ref_pass(input int c, input logic [3:0] f);
      bit n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      if (c == 14) return 1'b1;
      if (c == 15) return 1'b0;
      case (c / 2)
         0:       base = z;
         1:       base = cy;
         2:       base = n;
         3:       base = v;
         4:       base = cy && !z;
         5:       base = (n == v);
         default: base = (n == v) && !z;
      endcase
      return (c % 2 == 1) ? !base : base;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic [3:0] c, input logic [3:0] a,
                        input logic [1:0] fw, input logic p, input logic rw, input logic mw,
                        input logic nw);
      rst_n = r; en = e; Cond = c; ALUFlags = a; FlagW = fw;
      PCS = p; RegW = rw; MemW = mw; NoWrite = nw;
   endtask

   function automatic logic [7:0] model_out(input logic [3:0] f);
      bit pass, gate;
      pass = ref_pass(int'(Cond), f) && (rst_n == 1'b1);
      gate = pass && en;
      return {PCS & gate, RegW & ~NoWrite & gate, MemW & gate, 1'(pass), f};
   endfunction

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000};
      vecs[1]  = '{1'b1, 1'b1, 4'hE, 4'hF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0000};
      vecs[2]  = '{1'b1, 1'b1, 4'hE, 4'h6, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 4'b0000, 4'b0110};
      vecs[3]  = '{1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 4'b0110, 4'b0110};
      vecs[4]  = '{1'b1, 1'b1, 4'h1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0110, 4'b0110};
      vecs[5]  = '{1'b1, 1'b1, 4'hE, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0110, 4'b1111};
      vecs[6]  = '{1'b1, 1'b1, 4'hE, 4'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b1111, 4'b0011};
      vecs[7]  = '{1'b1, 1'b1, 4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0011, 4'b0000};
      vecs[8]  = '{1'b1, 1'b1, 4'h0, 4'h9, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
      vecs[9]  = '{1'b1, 1'b1, 4'hE, 4'h4, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0100};
      vecs[10] = '{1'b1, 1'b0, 4'hE, 4'hB, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0100, 4'b0100};
      vecs[11] = '{1'b1, 1'b1, 4'hC, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0100, 4'b0100};
      vecs[12] = '{1'b1, 1'b1, 4'h9, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0111, 4'b0100, 4'b0100};
      vecs[13] = '{1'b1, 1'b1, 4'hF, 4'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0100, 4'b0100};

      drive(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;

      // directed table
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].rst_n, vecs[i].en, vecs[i].cond, vecs[i].alu, vecs[i].fw,
               vecs[i].pcs, vecs[i].regw, vecs[i].memw, vecs[i].nowr);
         #2;
         check($sformatf("vec%0d_out", i), {PCSrc, RegWrite, MemWrite, CondEx, Flags},
               {vecs[i].exp_ctl, vecs[i].exp_flags});
         @(posedge clk); #1;
         check($sformatf("vec%0d_next", i), {4'b0000, Flags}, {4'b0000, vecs[i].exp_next});
      end

      // mid-cycle reset with FlagW active: reset wins, first edge after release updates
      drive(1'b1, 1'b1, 4'hE, 4'hA, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
      #1 rst_n = 1'b0;
      #1 check("midrst_async", {PCSrc, RegWrite, MemWrite, CondEx, Flags}, 8'b0000_0000);
      @(posedge clk); #1;
      check("midrst_hold", {4'b0000, Flags}, 8'b0000_0000);
      rst_n = 1'b1;
      #2 check("midrst_release", {PCSrc, RegWrite, MemWrite, CondEx, Flags}, 8'b1111_0000);
      @(posedge clk); #1;
      check("midrst_firstedge", {4'b0000, Flags}, 8'b0000_1010);

      // full Cond x Flags sweep
      for (int f = 0; f < 16; f++) begin
         drive(1'b1, 1'b1, 4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
         @(posedge clk); #1;
         FlagW = 2'b00;
         for (int c = 0; c < 16; c++) begin
            Cond = 4'(c);
            #1 check($sformatf("sweep_c%0d_f%0d", c, f), {7'b0000000, CondEx},
                     {7'b0000000, 1'(ref_pass(c, 4'(f)))});
         end
         #1;
         @(posedge clk); #1;
      end
      mflags = 4'hF;

      // bubble with FlagW=11 must hold flags
      drive(1'b1, 1'b0, 4'hE, 4'h0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
      #2 check("bubble_out", {PCSrc, RegWrite, MemWrite, CondEx, Flags}, 8'b0001_1111);
      @(posedge clk); #1;
      check("bubble_hold", {4'b0000, Flags}, {4'b0000, mflags});

      // randomized cycles against the reference model
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 4) != 0),
               4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom));
         if (!rst_n) mflags = 4'b0000;
         #2 check($sformatf("rnd%0d_out", k), {PCSrc, RegWrite, MemWrite, CondEx, Flags},
                  model_out(mflags));
         @(posedge clk);
         if (rst_n && en && ref_pass(int'(Cond), mflags)) begin
            if (FlagW[1]) mflags[3:2] = ALUFlags[3:2];
            if (FlagW[0]) mflags[1:0] = ALUFlags[1:0];
         end
         #1 check($sformatf("rnd%0d_flags", k), {4'b0000, Flags}, {4'b0000, mflags});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
